i2c_frame_counter: RTL
======================

Name: i2c_frame_counter

Overview:
- Parametrised successor to the I2C bit counter.
- Sequences a complete I2C byte frame on SCL: DATA_WIDTH data bits followed by one ACK slot.
- Provides shift-in/shift-out data, ACK drive/sample, a running byte count and a bit index.
- Sits between the SCL/SDA pad logic and the I2C controller FSM; the controller gates it with bit_count_enable.

Parameters:
- DATA_WIDTH, 8, data bits per frame (2..16).
- BYTE_CNT_W, 4, width of byte_count; saturates at 2^BYTE_CNT_W-1.
- MSB_FIRST, 1, 1 = shift MSB first (I2C standard), 0 = LSB first.

Ports:
- SCL  input  1  sole clock; all state updates on posedge SCL.
- RST  input  1  reset, asynchronous, active-low.
- bit_count_enable  input  1  frame sequencing enable, sampled on posedge SCL.
- dir  input  1  0 = receive (block drives ACK), 1 = transmit (block drives data, samples ACK).
- ack_drive  input  1  receive mode: 1 = drive ACK (SDA low) in ACK slot, 0 = NACK.
- sda_in  input  1  sampled SDA line.
- tx_data  input  DATA_WIDTH  byte to transmit.
- tx_load  input  1  load tx_data into shift register.
- sda_out  output  1  SDA drive value; 1 = released.
- rx_data  output  DATA_WIDTH  last completed received byte.
- rx_valid  output  1  one-SCL-cycle pulse when rx_data updates.
- bit_count  output  1  high while in ACK slot (all data bits counted).
- bit_index  output  CW  bits taken in current frame, CW = $clog2(DATA_WIDTH+1).
- byte_count  output  BYTE_CNT_W  completed frames since enable rose.
- ack_received  output  1  1 = last ACK slot sampled SDA low.
- arb_lost  output  1  arbitration lost flag (see Optional Feature).

Behaviour:
- Reset (RST low, async) clears all state.
  - State IDLE; bit_index 0, shift register 0, rx_data 0, rx_valid 0, bit_count 0, byte_count 0, ack_received 0, arb_lost 0.
  - sda_out is 1 while in reset.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- States: IDLE, DATA, ACK.
- IDLE:
  - bit_count_enable=0: remain in IDLE.
  - tx_load=1: shift register <= tx_data.
  - bit_count_enable=1: that edge counts as data bit 1. Shift in sda_in, bit_index <= 1, go to DATA.
- DATA, each posedge with enable=1:
  - Shift register shifts one position toward the output end and inserts sda_in at the far end; direction is set by MSB_FIRST.
  - bit_index increments.
  - On the edge where bit_index becomes DATA_WIDTH: go to ACK, bit_count <= 1, rx_data <= completed shift value, rx_valid <= 1 for exactly that cycle.
- ACK, next posedge with enable=1:
  - ack_received <= ~sda_in.
  - byte_count increments, saturating at max.
  - bit_index <= 0, bit_count <= 0, go to DATA.
  - If tx_load=1 on this edge, the shift register loads tx_data; otherwise it keeps its value.
- Enable low on any posedge in DATA or ACK:
  - Go to IDLE; bit_index 0, byte_count 0, bit_count 0.
  - rx_data and ack_received are held; a partial byte never asserts rx_valid.
- sda_out is combinational from registered state only:
  - DATA and dir=1: shift-register output bit.
  - ACK and dir=0: ~ack_drive.
  - All other cases: 1.
- tx_load in DATA state is ignored.
- Simultaneous enable rising and tx_load in IDLE: load takes priority. The loaded value's output bit is the first bit driven; the shift occurs on the following edge.

Optional Feature:
- Macro I2C_FRAME_ARB_CHECK_EN.
- Defined:
  - On any DATA-state edge with dir=1, sda_out=1 and sda_in=0: arb_lost <= 1.
  - arb_lost is sticky until enable goes low or reset.
  - While arb_lost=1, sda_out is forced to 1; counting continues.
- Undefined: arb_lost is tied to 0 and no compare logic is built.

Test Plan:
- Receive 0xA5, MSB_FIRST=1, ack_drive=1:
  - 8 enabled edges give rx_data=0xA5, rx_valid for 1 cycle, bit_count=1.
  - sda_out=0 in ACK; byte_count=1 after the 9th edge.
- Transmit 0x3C with tx_load in IDLE, dir=1:
  - sda_out sequence is 0,0,1,1,1,1,0,0.
  - sda_in=1 in ACK slot gives ack_received=0 (NACK).
- Drop enable after 5 data edges:
  - State IDLE, bit_index=0, byte_count=0, no rx_valid; rx_data keeps its previous value.
- BYTE_CNT_W=2, 5 consecutive frames: byte_count goes 1,2,3,3,3.
- Assert RST low mid-byte between SCL edges:
  - All outputs reset immediately without an SCL edge.
  - The next frame counts from bit 1.
- With I2C_FRAME_ARB_CHECK_EN, transmit 0xFF while bench drives sda_in=0 on bit 3:
  - arb_lost=1 from that edge; sda_out stays 1.
  - arb_lost clears when enable drops.

Source files
------------

// File: rtl/i2c_frame_counter.sv
// I2C byte-frame sequencer clocked by SCL: DATA_WIDTH data bits plus one ACK slot.
// Optional arbitration-loss detection is built when I2C_FRAME_ARB_CHECK_EN is defined.
module i2c_frame_counter #(
   parameter int DATA_WIDTH = 8,
   parameter int BYTE_CNT_W = 4,
   parameter bit MSB_FIRST  = 1'b1,
   localparam int CW = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  SCL,
   input  logic                  RST,
   input  logic                  bit_count_enable,
   input  logic                  dir,
   input  logic                  ack_drive,
   input  logic                  sda_in,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  sda_out,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  bit_count,
   output logic [CW-1:0]         bit_index,
   output logic [BYTE_CNT_W-1:0] byte_count,
   output logic                  ack_received,
   output logic                  arb_lost
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  bit_count_q, bit_count_d;
   logic [CW-1:0]         bit_index_q, bit_index_d;
   logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
   logic                  ack_received_q, ack_received_d;
   logic                  out_bit_s;

   // Moves the register one place toward its output end and inserts the new bit at the far end.
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                      input logic                  b);
      if (MSB_FIRST) begin
         return {cur[DATA_WIDTH-2:0], b};
      end else begin
         return {b, cur[DATA_WIDTH-1:1]};
      end
   endfunction

   assign out_bit_s = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];

   always_comb begin
      sda_out = 1'b1;
      if ((state_q == ST_DATA) && dir && !arb_lost) begin
         sda_out = out_bit_s;
      end else if ((state_q == ST_ACK) && !dir) begin
         sda_out = ~ack_drive;
      end else begin
         sda_out = 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      bit_count_d    = bit_count_q;
      bit_index_d    = bit_index_q;
      byte_count_d   = byte_count_q;
      ack_received_d = ack_received_q;
      if (!bit_count_enable) begin
         // Only an idle block accepts a load while disabled; an active frame is simply abandoned.
         if ((state_q == ST_IDLE) && tx_load) begin
            shift_d = tx_data;
         end else begin
            shift_d = shift_q;
         end
         state_d      = ST_IDLE;
         bit_index_d  = '0;
         byte_count_d = '0;
         bit_count_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tx_load) begin
                  shift_d = tx_data;
               end else begin
                  shift_d = shift_in(shift_q, sda_in);
               end
               bit_index_d = CW'(1);
               state_d     = ST_DATA;
            end
            ST_DATA: begin
               shift_d     = shift_in(shift_q, sda_in);
               bit_index_d = bit_index_q + CW'(1);
               if (bit_index_d == CW'(DATA_WIDTH)) begin
                  state_d     = ST_ACK;
                  bit_count_d = 1'b1;
                  rx_data_d   = shift_d;
                  rx_valid_d  = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_ACK: begin
               ack_received_d = ~sda_in;
               if (byte_count_q != {BYTE_CNT_W{1'b1}}) begin
                  byte_count_d = byte_count_q + BYTE_CNT_W'(1);
               end else begin
                  byte_count_d = byte_count_q;
               end
               bit_index_d = '0;
               bit_count_d = 1'b0;
               state_d     = ST_DATA;
               if (tx_load) begin
                  shift_d = tx_data;
               end else begin
                  shift_d = shift_q;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               bit_index_d = '0;
               bit_count_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge SCL or negedge RST) begin
      if (!RST) begin
         state_q        <= ST_IDLE;
         shift_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         bit_count_q    <= 1'b0;
         bit_index_q    <= '0;
         byte_count_q   <= '0;
         ack_received_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         bit_count_q    <= bit_count_d;
         bit_index_q    <= bit_index_d;
         byte_count_q   <= byte_count_d;
         ack_received_q <= ack_received_d;
      end
   end

`ifdef I2C_FRAME_ARB_CHECK_EN
   logic arb_lost_q, arb_lost_d;

   // Another master pulled SDA low while this block released it during a transmitted data bit.
   always_comb begin
      arb_lost_d = arb_lost_q;
      if (!bit_count_enable) begin
         arb_lost_d = 1'b0;
      end else if ((state_q == ST_DATA) && dir && sda_out && !sda_in) begin
         arb_lost_d = 1'b1;
      end else begin
         arb_lost_d = arb_lost_q;
      end
   end

   always_ff @(posedge SCL or negedge RST) begin
      if (!RST) begin
         arb_lost_q <= 1'b0;
      end else begin
         arb_lost_q <= arb_lost_d;
      end
   end

   assign arb_lost = arb_lost_q;
`else
   assign arb_lost = 1'b0;
`endif

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign bit_count    = bit_count_q;
   assign bit_index    = bit_index_q;
   assign byte_count   = byte_count_q;
   assign ack_received = ack_received_q;

endmodule
